multicycle_sequencer: RTL and testbench



---
 rtl/sequencer_pkg.sv | 13 +
 rtl/dff.sv | 14 +
 rtl/reg_n.sv | 27 ++
 rtl/multicycle_sequencer.sv | 96 +++++++++
 tb/tb_multicycle_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/sequencer_pkg.sv
// Shared constants and the terminal-count clamp used by the sequencer and the
// control unit's cycle-budget logic.
package sequencer_pkg;

  localparam int SEQ_WIDTH_DEFAULT = 6;
  localparam int SEQ_LAST_MULDIV   = 33;

  // A terminal count of 0 would never match a running count, so it means 1.
  function automatic logic [31:0] seq_clamp(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/dff.sv
// Codebase D flip-flop primitive with active-low asynchronous clear.
module dff (
  input  logic clk,
  input  logic clrn,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) q <= 1'b0;
    else       q <= d;
  end

endmodule

// File: rtl/reg_n.sv
// WIDTH-bit register of dff cells; sync clear to RST_VAL and hold are muxed in
// front of d so the primitive's async clear stays unused.
module reg_n #(
  parameter int               WIDTH   = 6,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] d_mux;

  assign d_mux = reset ? RST_VAL : (en ? d : q);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff u_dff (
      .clk  (clock),
      .clrn (1'b1),
      .d    (d_mux[i]),
      .q    (q[i])
    );
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// One-shot step counter for iterative datapath units: counts 1..last after
// start, pulses done on completion; supports stall, abort and back-to-back restart.
module multicycle_sequencer
  import sequencer_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] last,
  input  logic             stall,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             at_last
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] last_clamped;
  logic             term;

  assign last_clamped = WIDTH'(seq_clamp(32'(last)));
  assign term         = (count_q == last_q);

  // Single priority block; busy doubles as the IDLE/RUN state.
  always_comb begin
    count_d = count_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (!busy_q) begin
      if (start) begin
        count_d = WIDTH'(1);
        busy_d  = 1'b1;
        last_d  = last_clamped;
      end
    end else if (abort) begin
      count_d = '0;
      busy_d  = 1'b0;
    end else if (stall) begin
      count_d = count_q;
    end else if (term) begin
      done_d = 1'b1;
      if (start) begin
        count_d = WIDTH'(1);
        last_d  = last_clamped;
      end else begin
        count_d = '0;
        busy_d  = 1'b0;
      end
    end else begin
      count_d = count_q + WIDTH'(1);
    end
  end

  reg_n #(.WIDTH(WIDTH), .RST_VAL('0)) u_count (
    .clock (clock),
    .reset (reset),
    .en    (1'b1),
    .d     (count_d),
    .q     (count_q)
  );

  reg_n #(.WIDTH(WIDTH), .RST_VAL(WIDTH'(1))) u_last (
    .clock (clock),
    .reset (reset),
    .en    (1'b1),
    .d     (last_d),
    .q     (last_q)
  );

  dff u_busy (
    .clk  (clock),
    .clrn (1'b1),
    .d    (reset ? 1'b0 : busy_d),
    .q    (busy_q)
  );

  dff u_done (
    .clk  (clock),
    .clrn (1'b1),
    .d    (reset ? 1'b0 : done_d),
    .q    (done_q)
  );

  assign count   = count_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign at_last = busy_q && term && !stall;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: each step drives inputs, pushes the
// reference model's next outputs to a scoreboard, and compares after the edge.
module tb_multicycle_sequencer;
  localparam int W = 6;

  logic         clock = 1'b0;
  logic         reset = 1'b1, start = 1'b0, stall = 1'b0, abort = 1'b0;
  logic [W-1:0] last = '0;
  logic [W-1:0] count;
  logic         busy, done, at_last;

  typedef struct packed {
    logic [W-1:0] c;
    logic         b;
    logic         d;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] obs_q[$];
  int           checks = 0, failures = 0;
  int           n_busy, n_done, n_steps;
  logic [W-1:0] m_count = '0, m_last = W'(1);
  logic         m_busy = 1'b0;

  multicycle_sequencer #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .last    (last),
    .stall   (stall),
    .abort   (abort),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .at_last (at_last)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_busy = 0; n_done = 0; n_steps = 0;
    obs_q.delete();
  endtask

  // One clock cycle: drive, check at_last, model the edge, compare after it.
  task automatic step(input logic r, input logic s, input logic [W-1:0] l,
                      input logic st, input logic ab);
    exp_t         e;
    logic [W-1:0] lc;
    logic         m_done;
    reset = r; start = s; last = l; stall = st; abort = ab;
    #1;
    if (!r) chk("at_last", 32'(at_last), 32'(m_busy && (m_count == m_last) && !st));
    lc     = (l == '0) ? W'(1) : l;
    m_done = 1'b0;
    if (r) begin
      m_count = '0; m_busy = 1'b0; m_last = W'(1);
    end else if (!m_busy) begin
      if (s) begin m_count = W'(1); m_busy = 1'b1; m_last = lc; end
    end else if (ab) begin
      m_count = '0; m_busy = 1'b0;
    end else if (!st) begin
      if (m_count == m_last) begin
        m_done = 1'b1;
        if (s) begin m_count = W'(1); m_last = lc; end
        else   begin m_count = '0; m_busy = 1'b0; end
      end else begin
        m_count = m_count + W'(1);
      end
    end
    sb.push_back({m_count, m_busy, m_done});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("count", 32'(count), 32'(e.c));
    chk("busy",  32'(busy),  32'(e.b));
    chk("done",  32'(done),  32'(e.d));
    if (busy) n_busy++;
    if (done) n_done++;
    n_steps++;
    obs_q.push_back(count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] b2b_exp [6];
    b2b_exp = '{W'(1), W'(2), W'(3), W'(1), W'(2), W'(0)};
    #1;

    // Reset state
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, W'(7), 1'b1, 1'b1);
    chk("reset_count", 32'(count), 0);
    chk("reset_busy",  32'(busy),  0);
    idle(2);

    // Basic 33-step run
    step(1'b0, 1'b1, W'(33), 1'b0, 1'b0);
    chk("basic_first", 32'(count), 1);
    clr_stats();
    n_busy = 1;
    idle(34);
    chk("basic_busy_cycles", 32'(n_busy), 33);
    chk("basic_done_pulses", 32'(n_done), 1);
    chk("basic_idle_count",  32'(count),  0);

    // Stall at count 3 and count 5
    step(1'b0, 1'b1, W'(5), 1'b0, 1'b0);
    clr_stats();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("stall_hold3", 32'(count), 3);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("stall_at5", 32'(count), 5);
    stall = 1'b1;
    #1;
    chk("stall_at_last_low", 32'(at_last), 0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("stall_hold5", 32'(count), 5);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("stall_done_cycle", 32'(n_steps), 7);
    chk("stall_done", 32'(done), 1);

    // Abort with simultaneous start
    idle(1);
    step(1'b0, 1'b1, W'(10), 1'b0, 1'b0);
    idle(3);
    chk("abort_pre", 32'(count), 4);
    clr_stats();
    step(1'b0, 1'b1, W'(10), 1'b0, 1'b1);
    idle(1);
    chk("abort_no_done", 32'(n_done), 0);
    chk("abort_idle",    32'(busy),   0);
    step(1'b0, 1'b1, W'(2), 1'b0, 1'b0);
    chk("abort_fresh", 32'(count), 1);
    idle(3);

    // Back-to-back restart
    clr_stats();
    step(1'b0, 1'b1, W'(3), 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, W'(2), 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 6; i++) chk("b2b_seq", 32'(obs_q[i]), 32'(b2b_exp[i]));
    chk("b2b_done_pulses", 32'(n_done), 2);
    chk("b2b_busy_cycles", 32'(n_busy), 5);

    // last = 0 clamps to 1
    clr_stats();
    step(1'b0, 1'b1, W'(0), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("last0_done",  32'(done),  1);
    chk("last0_count", 32'(count), 0);

    // Full range, no wrap
    clr_stats();
    step(1'b0, 1'b1, W'(63), 1'b0, 1'b0);
    idle(62);
    chk("full_top", 32'(count), 63);
    idle(1);
    chk("full_busy_cycles", 32'(n_busy), 63);
    chk("full_done", 32'(done), 1);

    // Early start ignored
    clr_stats();
    step(1'b0, 1'b1, W'(5), 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b1, W'(9), 1'b0, 1'b0);
    chk("early_start_ignored", 32'(count), 3);
    idle(3);
    chk("early_done_at5", 32'(done), 1);
    chk("early_busy_cycles", 32'(n_busy), 5);

    // Reset mid-run
    clr_stats();
    step(1'b0, 1'b1, W'(33), 1'b0, 1'b0);
    idle(19);
    chk("midreset_pre", 32'(count), 20);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("midreset_count", 32'(count), 0);
    chk("midreset_busy",  32'(busy),  0);
    chk("midreset_done",  32'(done),  0);
    idle(2);
    chk("midreset_no_done", 32'(n_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
